// File: rtl/wb_pkg.sv
// Shared widths and the buffered-writeback entry type for the regfile write buffer.
package wb_pkg;

   localparam int WB_AW = 5;
   localparam int WB_DW = 32;

   typedef struct packed {
      logic [WB_AW-1:0] addr;
      logic [WB_DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending long-latency writebacks; every slot and its valid bit
// are visible so the parent can do CAM-style register lookups.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  wb_entry_t                push_entry,
   input  logic                     pop,
   output wb_entry_t                entries [DEPTH],
   output logic [DEPTH-1:0]         valid,
   output logic [$clog2(DEPTH)-1:0] rd_ptr,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] wr_ptr;

   assign full = (count == (PW + 1)'(DEPTH));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= '0;
      end else begin
         if (pop) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + PW'(1);
         end
         if (push) begin
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array is not reset; the valid vector alone decides what is live.
   always_ff @(posedge clk) begin
      if (push) entries[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/wb_write_buffer.sv
// Owns the regfile write port: main-pipeline writes win, long-latency results queue in wb_fifo.
// Optional macro WB_BYPASS_EN enables newest-entry forwarding on rs1_fwd/rs2_fwd.
module wb_write_buffer
   import wb_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pipe_we,
   input  logic [WB_AW-1:0]       pipe_addr,
   input  logic [WB_DW-1:0]       pipe_data,
   input  logic                   lu_valid,
   output logic                   lu_ready,
   input  logic [WB_AW-1:0]       lu_addr,
   input  logic [WB_DW-1:0]       lu_data,
   output logic                   RegWrite,
   output logic [WB_AW-1:0]       Wt_addr,
   output logic [WB_DW-1:0]       Wt_data,
   input  logic [WB_AW-1:0]       rs1_addr,
   input  logic [WB_AW-1:0]       rs2_addr,
   input  logic [WB_AW-1:0]       rd_addr,
   output logic                   rs1_busy,
   output logic                   rs2_busy,
   output logic                   rd_busy,
   output logic [WB_DW:0]         rs1_fwd,
   output logic [WB_DW:0]         rs2_fwd,
   output logic                   stall_req,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int SW = $clog2(STARVE_MAX + 1);

   wb_entry_t        entries [DEPTH];
   wb_entry_t        head;
   logic [DEPTH-1:0] valid;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             pw, push, pop, starved;
   logic [SW-1:0]    starve_cnt;

   assign lu_ready = !full;
   // Writes to x0 complete the handshake but never occupy a slot.
   assign push     = lu_valid && lu_ready && (lu_addr != '0);
   assign pw       = pipe_we && (pipe_addr != '0) && !stall_req;
   assign pop      = !pw && (count != '0);
   assign starved  = pw && (count != '0);
   assign head     = entries[rd_ptr];

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry ('{addr: lu_addr, data: lu_data}),
      .pop        (pop),
      .entries    (entries),
      .valid      (valid),
      .rd_ptr     (rd_ptr),
      .count      (count),
      .full       (full)
   );

   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      RegWrite = 1'b0;
      Wt_addr  = '0;
      Wt_data  = '0;
      if (pw) begin
         RegWrite = 1'b1;
         Wt_addr  = pipe_addr;
         Wt_data  = pipe_data;
      end else if (count != '0) begin
         RegWrite = 1'b1;
         Wt_addr  = head.addr;
         Wt_data  = head.data;
      end
   end

   always_comb begin
      rs1_busy = 1'b0;
      rs2_busy = 1'b0;
      rd_busy  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && rs1_addr != '0 && entries[i].addr == rs1_addr) rs1_busy = 1'b1;
         if (valid[i] && rs2_addr != '0 && entries[i].addr == rs2_addr) rs2_busy = 1'b1;
         if (valid[i] && rd_addr  != '0 && entries[i].addr == rd_addr)  rd_busy  = 1'b1;
      end
   end

`ifdef WB_BYPASS_EN
   // Walk oldest to newest so the last match, the youngest value, wins.
   always_comb begin
      logic [PW-1:0] idx;
      rs1_fwd = '0;
      rs2_fwd = '0;
      idx     = rd_ptr;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr + PW'(k);
         if (valid[idx] && rs1_addr != '0 && entries[idx].addr == rs1_addr)
            rs1_fwd = {1'b1, entries[idx].data};
         if (valid[idx] && rs2_addr != '0 && entries[idx].addr == rs2_addr)
            rs2_fwd = {1'b1, entries[idx].data};
      end
   end
`else
   assign rs1_fwd = '0;
   assign rs2_fwd = '0;
`endif

   // stall_req lasts exactly one cycle: the blocked pipe slot always drains the head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
         stall_req  <= 1'b0;
      end else begin
         starve_cnt <= starved ? starve_cnt + SW'(1) : '0;
         if (stall_req)
            stall_req <= 1'b0;
         else if (starved && starve_cnt == SW'(STARVE_MAX - 1))
            stall_req <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      assert (rst || !(pipe_we && stall_req))
         else $error("wb_write_buffer: pipe_we asserted while stall_req is high");
   end

endmodule

// File: tb/tb_wb_write_buffer.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based model.
module tb_wb_write_buffer;
   import wb_pkg::*;

   localparam int DEPTH      = 4;
   localparam int STARVE_MAX = 8;

   logic             clk, rst;
   logic             pipe_we, lu_valid, lu_ready, RegWrite;
   logic [WB_AW-1:0] pipe_addr, lu_addr, Wt_addr, rs1_addr, rs2_addr, rd_addr;
   logic [WB_DW-1:0] pipe_data, lu_data, Wt_data;
   logic             rs1_busy, rs2_busy, rd_busy, stall_req;
   logic [WB_DW:0]   rs1_fwd, rs2_fwd;
   logic [2:0]       count;

   int n_asserts = 0;
   int n_fail    = 0;

   // Reference model: queue of pending entries, oldest at index 0.
   wb_entry_t q[$];
   bit        m_stall;
   int        m_starve;

   wb_write_buffer #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
      .RegWrite(RegWrite), .Wt_addr(Wt_addr), .Wt_data(Wt_data),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
      .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
      .stall_req(stall_req), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp)
         else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      pipe_we = pwe; pipe_addr = pa; pipe_data = pd;
      lu_valid = lv; lu_addr = la; lu_data = ld;
      rs1_addr = r1; rs2_addr = r2; rd_addr = rd;
   endtask

   function automatic bit m_busy(input logic [4:0] a);
      foreach (q[i]) if (a != 0 && q[i].addr == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [32:0] m_fwd(input logic [4:0] a);
`ifdef WB_BYPASS_EN
      for (int i = q.size() - 1; i >= 0; i--)
         if (a != 0 && q[i].addr == a) return {1'b1, q[i].data};
`endif
      return 33'b0;
   endfunction

   task automatic check_model();
      bit pw_m;
      pw_m = pipe_we && pipe_addr != 0 && !m_stall;
      chk("lu_ready", lu_ready, q.size() < DEPTH);
      chk("count", count, q.size());
      chk("stall_req", stall_req, m_stall);
      chk("RegWrite", RegWrite, pw_m || q.size() > 0);
      chk("Wt_addr", Wt_addr, pw_m ? pipe_addr : (q.size() > 0 ? q[0].addr : 5'd0));
      chk("Wt_data", Wt_data, pw_m ? pipe_data : (q.size() > 0 ? q[0].data : 32'd0));
      chk("rs1_busy", rs1_busy, m_busy(rs1_addr));
      chk("rs2_busy", rs2_busy, m_busy(rs2_addr));
      chk("rd_busy", rd_busy, m_busy(rd_addr));
      chk("rs1_fwd", rs1_fwd, m_fwd(rs1_addr));
      chk("rs2_fwd", rs2_fwd, m_fwd(rs2_addr));
   endtask

   task automatic model_reset();
      q.delete();
      m_stall  = 1'b0;
      m_starve = 0;
   endtask

   task automatic model_edge();
      int sz;
      bit pw_m, starving, next_stall;
      sz         = q.size();
      pw_m       = pipe_we && pipe_addr != 0 && !m_stall;
      starving   = pw_m && sz > 0;
      // A stall cycle always retires the head, which releases the stall.
      next_stall = !m_stall && starving && (m_starve + 1 == STARVE_MAX);
      m_starve   = starving ? m_starve + 1 : 0;
      m_stall    = next_stall;
      if (!pw_m && sz > 0) void'(q.pop_front());
      if (lu_valid && sz < DEPTH && lu_addr != 0) q.push_back('{addr: lu_addr, data: lu_data});
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset(); else model_edge();
      #1;
   endtask

   task automatic step();
      #1;
      check_model();
      tick();
   endtask

   initial begin
      // Reset with a pending lu_valid.
      rst = 1'b1;
      drive(0, 0, 0, 1, 5'd3, 32'h1234, 0, 0, 0);
      model_reset();
      #3;
      chk("rst_lu_ready", lu_ready, 1);
      chk("rst_RegWrite", RegWrite, 0);
      chk("rst_count", count, 0);
      chk("rst_stall_req", stall_req, 0);
      tick(); tick();
      rst = 1'b0;

      // Single push of x5=0xAA with the pipe idle.
      drive(0, 0, 0, 1, 5'd5, 32'hAA, 5'd5, 0, 0);
      #1; check_model();
      chk("push_busy_same_cycle", rs1_busy, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 5'd5, 0, 0);
      #1; check_model();
      chk("drain_RegWrite", RegWrite, 1);
      chk("drain_Wt_addr", Wt_addr, 5);
      chk("drain_Wt_data", Wt_data, 32'hAA);
      chk("drain_busy_head", rs1_busy, 1);
      tick();
      #1; check_model();
      chk("after_drain_busy", rs1_busy, 0);
      tick();

      // Fill the FIFO while the pipe writes x1 every cycle.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 5'd1, 32'h100 + i, 1, 5'(10 + i), 32'h200 + i, 5'd11, 5'd13, 5'd1);
         step();
      end
      drive(1, 5'd1, 32'h1FF, 1, 5'd20, 32'h2FF, 5'd20, 0, 0);
      #1; check_model();
      chk("full_lu_ready", lu_ready, 0);
      chk("full_Wt_addr_pipe", Wt_addr, 1);
      tick();
      chk("full_count_held", count, 4);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1; check_model();
      chk("full_drop_head", Wt_addr, 10);
      tick();
      for (int i = 0; i < 3; i++) step();
      chk("full_drained", count, 0);

      // Starvation with a single buffered entry.
      drive(1, 5'd2, 32'h22, 1, 5'd9, 32'h99, 0, 0, 5'd9);
      step();
      for (int k = 0; k < STARVE_MAX; k++) begin
         drive(1, 5'd3, 32'(k), 0, 0, 0, 0, 0, 5'd9);
         step();
      end
      chk("starve_stall_set", stall_req, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1; check_model();
      chk("starve_head_addr", Wt_addr, 9);
      chk("starve_head_data", Wt_data, 32'h99);
      tick();
      chk("starve_stall_clear", stall_req, 0);
      chk("starve_count", count, 0);

      // Writes to x0 from both sources.
      drive(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 0, 0, 0);
      #1; check_model();
      chk("x0_lu_ready", lu_ready, 1);
      chk("x0_RegWrite", RegWrite, 0);
      tick();
      chk("x0_count", count, 0);

`ifdef WB_BYPASS_EN
      drive(1, 5'd1, 32'h5, 1, 5'd7, 32'd1, 0, 0, 0); step();
      drive(1, 5'd1, 32'h6, 1, 5'd7, 32'd2, 0, 0, 0); step();
      drive(1, 5'd1, 32'h7, 0, 0, 0, 0, 5'd7, 0);
      #1; check_model();
      chk("fwd_newest", rs2_fwd, {1'b1, 32'd2});
      rs2_addr = 5'd0;
      #1;
      chk("fwd_x0", rs2_fwd, 33'b0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(); step();
`endif

      // Reset mid-operation discards buffered entries immediately.
      drive(1, 5'd1, 32'h1, 1, 5'd4, 32'h44, 0, 0, 0); step(); step();
      #2 rst = 1'b1;
      #1;
      chk("midrst_count", count, 0);
      chk("midrst_lu_ready", lu_ready, 1);
      chk("midrst_RegWrite", RegWrite, 1);
      model_reset();
      tick();
      rst = 1'b0;

      // Random traffic; the bench plays decode and honours stall_req.
      for (int c = 0; c < 400; c++) begin
         drive(!m_stall && ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
